// File: rtl/dma_pkg.sv
// Shared types and AXI encodings for the AXI4 burst DMA master.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_A,
    ST_WR_D,
    ST_WR_B,
    ST_FIN
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] STRB_WORD      = 4'hF;

endpackage

// File: rtl/dma_burst_calc.sv
// Sizes the next INCR burst from the words still to move and the current word address.
module dma_burst_calc #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic [CNT_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] addr,
  output logic [LEN_W:0]    beats,
  output logic [LEN_W-1:0]  ax_len,
  output logic [ADDR_W-1:0] next_addr
);

  always_comb begin
    if (remaining > CNT_W'(MAX_BURST)) begin
      beats = (LEN_W+1)'(MAX_BURST);
    end else begin
      beats = remaining[LEN_W:0];
    end
    // ax_len is meaningless when remaining is zero; the FSM never issues a burst then
    ax_len    = LEN_W'(beats - (LEN_W+1)'(1));
    next_addr = addr + (ADDR_W'(beats) << 2);
  end

endmodule

// File: rtl/axi_dma_master.sv
// AXI4 burst master: splits one {dir, addr, count} command into INCR bursts, one transaction at a time.
module axi_dma_master
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  parameter int MST_ID    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_len,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              err_q;

  logic [LEN_W:0]    calc_beats;
  logic [LEN_W-1:0]  calc_len;
  logic [ADDR_W-1:0] calc_next;

  logic r_hs, w_hs;

  dma_burst_calc #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .CNT_W     (CNT_W),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .remaining (rem_q),
    .addr      (addr_q),
    .beats     (calc_beats),
    .ax_len    (calc_len),
    .next_addr (calc_next)
  );

  assign r_hs = rvalid && rd_ready;
  assign w_hs = wr_valid && wready;

  // Address channels are held stable from the registered address/remaining count
  assign arid    = ID_W'(MST_ID);
  assign araddr  = addr_q;
  assign arlen   = calc_len;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign awid    = ID_W'(MST_ID);
  assign awaddr  = addr_q;
  assign awlen   = calc_len;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = STRB_WORD;
  assign rd_data = rdata;
  assign wdata   = wr_data;
  assign wlast   = (state_q == ST_WR_D) && (beat_cnt_q == len_q);
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    bready    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          if (cmd_len == '0)   state_d = ST_FIN;
          else if (cmd_write)  state_d = ST_WR_A;
          else                 state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        if (r_hs && rlast) state_d = (rem_q == CNT_W'(1)) ? ST_FIN : ST_RD_A;
      end
      ST_WR_A: begin
        awvalid = 1'b1;
        if (awready) state_d = ST_WR_D;
      end
      ST_WR_D: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        if (w_hs && wlast) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        bready = 1'b1;
        if (bvalid) state_d = (rem_q == '0) ? ST_FIN : ST_WR_A;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      next_addr_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= {cmd_addr[ADDR_W-1:2], 2'b00};
            rem_q  <= cmd_len;
            err_q  <= 1'b0;
          end
        end
        ST_RD_A: begin
          if (arready) begin
            len_q       <= calc_len;
            next_addr_q <= calc_next;
          end
        end
        ST_RD_D: begin
          if (r_hs) begin
            rem_q <= rem_q - CNT_W'(1);
            if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (rlast) addr_q <= next_addr_q;
          end
        end
        ST_WR_A: begin
          if (awready) begin
            len_q       <= calc_len;
            next_addr_q <= calc_next;
            beat_cnt_q  <= '0;
          end
        end
        ST_WR_D: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            rem_q      <= rem_q - CNT_W'(1);
          end
        end
        ST_WR_B: begin
          if (bvalid) begin
            if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            addr_q <= next_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // IDs are not checked and the low address bits are forced to a word boundary
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, cmd_addr[1:0], calc_beats};

endmodule

// File: tb/tb_axi_dma_master.sv
// Randomized bench for axi_dma_master: AXI SRAM slave model, stream agents and a command-level reference.
module tb_axi_dma_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        done, err, busy;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  axi_dma_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .done(done), .err(err), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave memory and bus-side state
  logic [31:0] mem [0:1023];
  bit          r_act, b_pend;
  logic [31:0] r_addr, w_addr;
  int          r_left, w_left;
  int          r_beat, b_idx, n_rd;
  int          r_err_beat = -1, b_err_idx = -1;
  int          stall_at = -1, stall_len = 0;
  bit          stalling;
  logic [31:0] ar_a[$], aw_a[$], rd_got[$], wq[$];
  logic [3:0]  ar_l[$], aw_l[$];

  // Reference expectations for the current command
  logic [31:0] exp_ba[$], exp_data[$];
  logic [3:0]  exp_bl[$];
  logic [31:0] cur_base;
  int          cur_len;
  bit          cur_wr, exp_err;

  always @(negedge clk) begin
    if (rst) begin
      arready = 0; awready = 0; rvalid = 0; wready = 0; bvalid = 0;
      rd_ready = 0; wr_valid = 0; rlast = 0; rresp = 0; bresp = 0;
      rdata = 0; rid = 0; bid = 0; wr_data = 0;
      r_act = 0; b_pend = 0; w_left = 0; stalling = 0;
    end else begin
      arready = ($urandom % 4) != 0;
      awready = ($urandom % 4) != 0;
      rvalid  = r_act && (($urandom % 4) != 0);
      rdata   = mem[r_addr[11:2]];
      rlast   = (r_left == 1);
      rresp   = (r_beat == r_err_beat) ? 2'b10 : 2'b00;
      rid     = 4'($urandom);
      wready  = ($urandom % 4) != 0;
      bvalid  = b_pend && (($urandom % 3) != 0);
      bresp   = (b_idx == b_err_idx) ? 2'b10 : 2'b00;
      bid     = 4'($urandom);
      stalling = (n_rd == stall_at) && (stall_len > 0);
      if (stalling) begin
        rd_ready = 0;
        stall_len--;
      end else begin
        rd_ready = ($urandom % 3) != 0;
      end
      wr_valid = (wq.size() > 0) && (($urandom % 3) != 0);
      wr_data  = (wq.size() > 0) ? wq[0] : $urandom;
    end
    #1;
    if (!rst) begin
      if (stalling) check("rready_during_stall", rready, 0);
      if (rd_valid && rd_ready) begin
        rd_got.push_back(rd_data);
        n_rd++;
      end
      if (rvalid && rready) begin
        r_beat++;
        r_addr = r_addr + 4;
        r_left--;
        if (r_left == 0) r_act = 0;
      end
      if (arvalid && arready) begin
        ar_a.push_back(araddr);
        ar_l.push_back(arlen);
        check("ar_id_size_burst", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
        r_act = 1; r_addr = araddr; r_left = int'(arlen) + 1;
      end
      if (wvalid && wready) begin
        check("wlast_position", wlast, (w_left == 1));
        mem[w_addr[11:2]] = wdata;
        w_addr = w_addr + 4;
        w_left--;
        if (w_left == 0) b_pend = 1;
      end
      if (wr_valid && wr_ready) void'(wq.pop_front());
      if (awvalid && awready) begin
        aw_a.push_back(awaddr);
        aw_l.push_back(awlen);
        check("aw_id_size_burst_strb_wvalid", {awid, awsize, awburst, wstrb, wvalid},
              {4'd0, 3'b010, 2'b01, 4'hF, 1'b0});
        w_addr = awaddr; w_left = int'(awlen) + 1;
      end
      if (bvalid && bready) begin
        b_pend = 0;
        b_idx++;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input int len,
                       input int rerr, input int berr, input bit seq);
    logic [31:0] a;
    logic [31:0] d;
    int rem, b;
    bit got;
    ar_a.delete(); ar_l.delete(); aw_a.delete(); aw_l.delete();
    rd_got.delete(); wq.delete();
    exp_ba.delete(); exp_bl.delete(); exp_data.delete();
    r_beat = 0; b_idx = 0; n_rd = 0; r_err_beat = rerr; b_err_idx = berr;
    cur_base = addr & ~32'h3; cur_len = len; cur_wr = wr;
    a = cur_base; rem = len;
    while (rem > 0) begin
      b = (rem > 4) ? 4 : rem;
      exp_ba.push_back(a);
      exp_bl.push_back(4'(b - 1));
      a = a + 32'(4 * b);
      rem -= b;
    end
    for (int i = 0; i < len; i++) begin
      if (wr) begin
        d = seq ? 32'(i + 1) : $urandom;
        wq.push_back(d);
        exp_data.push_back(d);
      end else begin
        exp_data.push_back(mem[((cur_base >> 2) + 32'(i)) & 32'd1023]);
      end
    end
    exp_err = wr ? (berr >= 0 && berr < exp_ba.size()) : (rerr >= 0 && rerr < len);
    cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len); cmd_valid = 1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (cmd_ready) got = 1;
      else begin
        @(posedge clk); #2;
      end
    end
    check("cmd_accept", got, 1);
    @(posedge clk); #2;
    cmd_valid = 0;
    cmd_write = $urandom; cmd_addr = $urandom; cmd_len = 16'($urandom);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic finish_cmd(input string tag);
    bit seen;
    int cyc;
    logic [31:0] ga[$];
    logic [3:0]  gl[$];
    int n;
    seen = 0; cyc = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk); #2;
      cyc++;
      if (done) seen = 1;
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_err"}, err, exp_err);
    if (cur_len == 0) check({tag, "_len0_latency_ok"}, (cyc <= 2), 1);
    ga = cur_wr ? aw_a : ar_a;
    gl = cur_wr ? aw_l : ar_l;
    check({tag, "_burst_count"}, ga.size(), exp_ba.size());
    check({tag, "_other_dir_idle"}, cur_wr ? ar_a.size() : aw_a.size(), 0);
    n = (ga.size() < exp_ba.size()) ? ga.size() : exp_ba.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_ax_addr"}, ga[i], exp_ba[i]);
      check({tag, "_ax_len"}, gl[i], exp_bl[i]);
    end
    if (cur_wr) begin
      check({tag, "_wr_stream_drained"}, wq.size(), 0);
      check({tag, "_b_count"}, b_idx, exp_ba.size());
      for (int i = 0; i < cur_len; i++)
        check({tag, "_mem_word"}, mem[((cur_base >> 2) + 32'(i)) & 32'd1023], exp_data[i]);
    end else begin
      check({tag, "_rd_count"}, rd_got.size(), cur_len);
      n = (rd_got.size() < cur_len) ? rd_got.size() : cur_len;
      for (int i = 0; i < n; i++) check({tag, "_rd_word"}, rd_got[i], exp_data[i]);
    end
    @(negedge clk); #2;
    check({tag, "_done_one_cycle_busy_low"}, {done, busy}, 2'b00);
  endtask

  initial begin
    bit got;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", {cmd_ready, arvalid, awvalid, wvalid, rready, bready, done, busy, err}, 9'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #2;
    check("idle_cmd_ready", {cmd_ready, busy}, 2'b10);

    issue(0, 32'h100, 4, -1, -1, 0);  finish_cmd("rd4");
    issue(0, 32'h0, 10, -1, -1, 0);   finish_cmd("rd10");
    issue(1, 32'h40, 5, -1, -1, 1);   finish_cmd("wr5");
    issue(0, 32'h40, 5, -1, -1, 0);   finish_cmd("rdback5");
    check("rdback_first_word", exp_data[0], 32'd1);

    stall_at = 2; stall_len = 20;
    issue(0, 32'h200, 8, -1, -1, 0);  finish_cmd("rd_stall");
    stall_at = -1;

    issue(1, 32'h302, 12, -1, 1, 0);  finish_cmd("wr_slverr");
    issue(0, 32'h300, 12, -1, -1, 0); finish_cmd("rd_after_err");
    issue(0, 32'h500, 7, 3, -1, 0);   finish_cmd("rd_rresp_err");

    // Reset while read data is streaming
    issue(0, 32'h80, 8, -1, -1, 0);
    got = 0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(posedge clk); #2;
      if (rd_got.size() >= 2) got = 1;
    end
    check("rst_mid_two_beats", got, 1);
    rst = 1;
    @(posedge clk); #2;
    check("rst_mid_outputs", {arvalid, rready, busy, done, cmd_ready}, 5'd0);
    rst = 0;
    @(posedge clk); #2;
    check("rst_mid_back_idle", {cmd_ready, busy}, 2'b10);
    issue(0, 32'h80, 0, -1, -1, 0);   finish_cmd("len0_rd");
    issue(1, 32'h84, 0, -1, -1, 0);   finish_cmd("len0_wr");

    for (int t = 0; t < 10; t++) begin
      bit wr;
      int len, rerr, berr;
      wr   = 1'($urandom);
      len  = $urandom % 19;
      rerr = (($urandom % 3) == 0) ? int'($urandom % (len + 1)) : -1;
      berr = (($urandom % 3) == 0) ? int'($urandom % 6) : -1;
      issue(wr, $urandom % 4096, len, rerr, berr, 0);
      finish_cmd("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
